// File: rtl/random1_pkg.sv
// Shared constants and next-state function for the random1 Galois LFSR.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_POLY / DEFAULT_SEED : generator defaults
//   MAX_WIDTH                                    : widest state lfsr_step supports
//   lfsr_step                                    : one Galois shift-right step
package random1_pkg;

  localparam int          DEFAULT_WIDTH = 16;
  localparam int          MAX_WIDTH     = 64;

  // x^16 + x^14 + x^13 + x^11 + 1 in shift-right Galois form.
  localparam logic [15:0] DEFAULT_POLY  = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

  typedef logic [MAX_WIDTH-1:0] lfsr_word_t;

  // The function works on a zero-extended word so one definition serves any
  // WIDTH up to MAX_WIDTH. The caller zero-extends the state and the mask.
  // Because both arrive zero-extended, the bits above WIDTH stay zero, so
  // truncating the result back to WIDTH is exact.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state,
                                           input lfsr_word_t poly);
    lfsr_word_t shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/random1.sv
// Pseudo-random word generator: a Galois LFSR with seed load and step enable.
// Latency: a seed load or a step appears on RANDOM_WORD one cycle after its edge.
// Backpressure: none; ENABLE gates stepping, and the generator holds while ENABLE is low.
//
// Ports:
//   CLK          in   1      rising-edge clock
//   RST          in   1      asynchronous active-low reset; loads DEFAULT_SEED
//   SEED_DAT     in   WIDTH  seed value, sampled only while SEED_STB=1
//   SEED_STB     in   1      seed-load strobe; has priority over ENABLE
//   ENABLE       in   1      advance one LFSR step per rising edge
//   RANDOM_WORD  out  WIDTH  registered LFSR state
module random1 #(
  parameter int               WIDTH        = random1_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(random1_pkg::DEFAULT_POLY),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(random1_pkg::DEFAULT_SEED)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SEED_DAT,
  input  logic             SEED_STB,
  input  logic             ENABLE,
  output logic [WIDTH-1:0] RANDOM_WORD
);

  import random1_pkg::*;

  // Parameter sanity checks. A zero default seed would lock the LFSR in the
  // all-zero state. A mask without its top bit set makes the step
  // non-invertible, so zero could become reachable.
  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("random1: WIDTH must be in 2..%0d", MAX_WIDTH);
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("random1: DEFAULT_SEED must be nonzero");
    end
    if (POLY[WIDTH-1] == 1'b0) begin : g_bad_poly
      $error("random1: POLY must have its top bit set");
    end
  endgenerate

  logic [WIDTH-1:0] state;

  // The upstream logic releases reset synchronously to CLK. The flop can
  // therefore step on the very first rising edge after RST goes high. No extra
  // release stage is added here, because one would delay that first step.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= DEFAULT_SEED;
    end else if (SEED_STB) begin
      // A zero seed would lock the generator, so it is replaced with the default.
      state <= (SEED_DAT == '0) ? DEFAULT_SEED : SEED_DAT;
    end else if (ENABLE) begin
      state <= WIDTH'(lfsr_step(MAX_WIDTH'(state), MAX_WIDTH'(POLY)));
    end
  end

  assign RANDOM_WORD = state;

endmodule

// File: tb/tb_random1.sv
// Directed self-checking bench for random1. A scoreboard queue holds the
// expected words, and fixed known-answer words come from the generator definition.
module tb_random1;

  logic        CLK;
  logic        RST;
  logic [15:0] SEED_DAT;
  logic        SEED_STB;
  logic        ENABLE;
  logic [15:0] RANDOM_WORD;

  random1 dut (
    .CLK         (CLK),
    .RST         (RST),
    .SEED_DAT    (SEED_DAT),
    .SEED_STB    (SEED_STB),
    .ENABLE      (ENABLE),
    .RANDOM_WORD (RANDOM_WORD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          vectors;
  int          miscompares;
  logic [15:0] model;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and push the model's
  // expected word. After the rising edge, pop the word and compare it.
  task automatic apply(input logic stb, input logic [15:0] dat, input logic en, input string tag);
    logic [15:0] expv;
    @(negedge CLK);
    SEED_STB = stb;
    SEED_DAT = dat;
    ENABLE   = en;
    if (stb)     model = (dat == 16'h0000) ? 16'hACE1 : dat;
    else if (en) model = ref_step(model);
    exp_q.push_back(model);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check(tag, RANDOM_WORD, 16'hxxxx);
    end else begin
      expv = exp_q.pop_front();
      check(tag, RANDOM_WORD, expv);
    end
  endtask

  initial begin
    int zeros;
    int early;
    int seq_err;
    logic [15:0] held;

    vectors     = 0;
    miscompares = 0;
    RST      = 1'b1;
    SEED_STB = 1'b0;
    SEED_DAT = 16'h0000;
    ENABLE   = 1'b0;

    // Assert reset between clock edges. The state must change without an edge.
    #2;
    RST = 1'b0;
    #1;
    check("reset_async", RANDOM_WORD, 16'hACE1);

    // Reset must dominate the seed strobe and the step enable.
    SEED_STB = 1'b1;
    SEED_DAT = 16'h1234;
    ENABLE   = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_dominates", RANDOM_WORD, 16'hACE1);

    @(negedge CLK);
    SEED_STB = 1'b0;
    ENABLE   = 1'b0;
    RST      = 1'b1;
    model    = 16'hACE1;

    // After release, the word holds while ENABLE is low.
    apply(1'b0, 16'h0000, 1'b0, "hold_after_reset0");
    apply(1'b0, 16'h0000, 1'b0, "hold_after_reset1");
    check("hold_after_reset_const", RANDOM_WORD, 16'hACE1);

    // Step from the reset seed.
    apply(1'b0, 16'h0000, 1'b1, "step1");
    check("step1_const", RANDOM_WORD, 16'hE270);
    apply(1'b0, 16'h0000, 1'b1, "step2");
    check("step2_const", RANDOM_WORD, 16'h7138);

    // A seed load with ENABLE high loads the seed and does not step.
    apply(1'b1, 16'hCAFE, 1'b1, "seed_load");
    check("seed_load_const", RANDOM_WORD, 16'hCAFE);
    apply(1'b0, 16'h0000, 1'b1, "seed_step1");
    check("seed_step1_const", RANDOM_WORD, 16'h657F);
    apply(1'b0, 16'h0000, 1'b1, "seed_step2");
    check("seed_step2_const", RANDOM_WORD, 16'h86BF);
    apply(1'b0, 16'h0000, 1'b1, "seed_step3");
    check("seed_step3_const", RANDOM_WORD, 16'hF75F);

    // With ENABLE low the word freezes.
    held = RANDOM_WORD;
    apply(1'b0, 16'h0000, 1'b0, "hold0");
    apply(1'b0, 16'h5555, 1'b0, "hold1");
    check("hold_const", RANDOM_WORD, held);

    // A strobe held high reloads every cycle, so the word stays at the seed.
    apply(1'b1, 16'h1234, 1'b1, "multi_stb0");
    apply(1'b1, 16'h1234, 1'b1, "multi_stb1");
    apply(1'b1, 16'h1234, 1'b1, "multi_stb2");
    check("multi_stb_const", RANDOM_WORD, 16'h1234);

    // Mid-run reset: step a little, then pull reset low between edges.
    apply(1'b0, 16'h0000, 1'b1, "pre_reset_step0");
    apply(1'b0, 16'h0000, 1'b1, "pre_reset_step1");
    #2;
    RST = 1'b0;
    #1;
    check("midrun_reset_async", RANDOM_WORD, 16'hACE1);
    @(negedge CLK);
    // Release with ENABLE high. The first rising edge after release must step.
    RST      = 1'b1;
    SEED_STB = 1'b0;
    ENABLE   = 1'b1;
    model    = 16'hACE1;
    @(posedge CLK);
    #1;
    check("first_step_after_release", RANDOM_WORD, 16'hE270);
    model = ref_step(model);
    apply(1'b0, 16'h0000, 1'b1, "resume_step");
    check("resume_step_const", RANDOM_WORD, 16'h7138);

    // A zero seed is replaced with the default seed.
    apply(1'b1, 16'h0000, 1'b1, "zero_seed");
    check("zero_seed_const", RANDOM_WORD, 16'hACE1);

    // Full period from the default seed.
    @(negedge CLK);
    SEED_STB = 1'b0;
    ENABLE   = 1'b1;
    zeros   = 0;
    early   = 0;
    seq_err = 0;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge CLK);
      #1;
      model = ref_step(model);
      if (RANDOM_WORD === 16'h0000) zeros++;
      if (i < 65535 && RANDOM_WORD === 16'hACE1) early++;
      if (RANDOM_WORD !== model) seq_err++;
    end
    check_int("period_sequence_errors", seq_err, 0);
    check_int("period_zero_states", zeros, 0);
    check_int("period_early_repeat", early, 0);
    check("period_return", RANDOM_WORD, 16'hACE1);

    ENABLE = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
